// File: rtl/calc_operand_engine.sv
// calc_operand_engine: latches operands/opcode from the stage levels and computes add/sub/mul/div answers
module calc_operand_engine #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   sw,
    input  logic               store_num1,
    input  logic               store_num2,
    input  logic               store_operation,
    input  logic               display_32bit_answer,
    output logic [2*WIDTH-1:0] answer,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   num_a_q, num_a_d, num_b_q, num_b_d, wb_q, wb_d;
    logic [1:0]         op_q, op_d;
    logic               disp_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] wa_q, wa_d, acc_q, acc_d, answer_q, answer_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               start, ge, last;
    logic [2*WIDTH-1:0] mul_acc, div_acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_nx;

    assign answer      = answer_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

    // Next-state logic: operand capture, start detection and one mul/div step per EXEC cycle.
    // MUL keeps multiplicand in wa, multiplier in wb, product in acc; DIV keeps {remainder, dividend/quotient} in acc.
    always_comb begin
        start    = display_32bit_answer & ~disp_q & ~busy_q;
        last     = cnt_q == CW'(WIDTH - 1);
        mul_acc  = wb_q[0] ? acc_q + wa_q : acc_q;
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = rem_sh >= {1'b0, wb_q};
        rem_nx   = ge ? WIDTH'(rem_sh - {1'b0, wb_q}) : rem_sh[WIDTH-1:0];
        div_acc  = {rem_nx, acc_q[WIDTH-2:0], ge};
        num_a_d  = (!busy_q && store_num1) ? sw : num_a_q;
        num_b_d  = (!busy_q && store_num2) ? sw : num_b_q;
        op_d     = (!busy_q && store_operation) ? sw[1:0] : op_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        wa_d     = wa_q;
        wb_d     = wb_q;
        acc_d    = acc_q;
        answer_d = answer_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    wa_d    = {{WIDTH{1'b0}}, num_a_q};
                    wb_d    = num_b_q;
                    acc_d   = (op_q == OP_MUL) ? '0 : {{WIDTH{1'b0}}, num_a_q};
                    dbz_d   = 1'b0;
                end
            end
            EXEC: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    answer_d = (op_q == OP_ADD) ? wa_q + {{WIDTH{1'b0}}, wb_q}
                                                : wa_q - {{WIDTH{1'b0}}, wb_q};
                    state_d  = DONE;
                end else if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    wa_d  = wa_q << 1;
                    wb_d  = wb_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        answer_d = mul_acc;
                        state_d  = DONE;
                    end
                end else if (wb_q == '0) begin
                    answer_d = '1;
                    dbz_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d = div_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        answer_d = div_acc;
                        state_d  = DONE;
                    end
                end
                busy_d = state_d != DONE;
                done_d = state_d == DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            num_a_q  <= '0;
            num_b_q  <= '0;
            op_q     <= 2'b00;
            disp_q   <= 1'b0;
            cnt_q    <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
            acc_q    <= '0;
            answer_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_a_q  <= num_a_d;
            num_b_q  <= num_b_d;
            op_q     <= op_d;
            disp_q   <= display_32bit_answer;
            cnt_q    <= cnt_d;
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            acc_q    <= acc_d;
            answer_q <= answer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_calc_operand_engine.sv
// tb_calc_operand_engine: directed scoreboard bench for calc_operand_engine
module tb_calc_operand_engine;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic        store_num1 = 0, store_num2 = 0, store_operation = 0, display_32bit_answer = 0;
    logic [31:0] answer;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [31:0] ans;
        logic        dbz;
        int          busy_cycles;
    } exp_t;
    exp_t sb[$];
    int passed = 0, total = 0;

    calc_operand_engine #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .store_num1(store_num1), .store_num2(store_num2), .store_operation(store_operation),
        .display_32bit_answer(display_32bit_answer),
        .answer(answer), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total += 1;
        assert (obs === exp) passed += 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        sw = a; store_num1 = 1;
        @(negedge clk);
        store_num1 = 0; sw = b; store_num2 = 1;
        @(negedge clk);
        store_num2 = 0; sw = {14'd0, op}; store_operation = 1;
        @(negedge clk);
        store_operation = 0; sw = 16'h5A5A;
        @(negedge clk);
    endtask

    task automatic start_op(input logic [31:0] ans, input logic dbz, input int bc);
        exp_t e;
        e.ans = ans; e.dbz = dbz; e.busy_cycles = bc;
        sb.push_back(e);
        display_32bit_answer = 1;
        @(negedge clk);
        display_32bit_answer = 0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int bc = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            if (busy) bc++;
            @(negedge clk);
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        e = sb.pop_front();
        chk({tag, " answer"}, answer, e.ans);
        chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk({tag, " busy_cycles"}, bc, e.busy_cycles);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clk);
        chk("reset answer", answer, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        load(16'hFFFF, 16'h0001, 2'b00); start_op(32'h0001_0000, 0, 1); wait_done("add");
        load(16'h0003, 16'h0005, 2'b01); start_op(32'hFFFF_FFFE, 0, 1); wait_done("sub_neg");
        load(16'h0005, 16'h0003, 2'b01); start_op(32'h0000_0002, 0, 1); wait_done("sub_pos");
        load(16'h1234, 16'h0010, 2'b10); start_op(32'h0001_2340, 0, 16); wait_done("mul");
        load(16'hFFFF, 16'hFFFF, 2'b10); start_op(32'hFFFE_0001, 0, 16); wait_done("mul_max");
        load(16'd100, 16'd7, 2'b11); start_op(32'h0002_000E, 0, 16); wait_done("div");
        load(16'd100, 16'd0, 2'b11); start_op(32'hFFFF_FFFF, 1, 1); wait_done("div0");
        load(16'd100, 16'd7, 2'b11); start_op(32'h0002_000E, 0, 16); wait_done("div_clear");

        // Captures and restarts while multiplying must be ignored.
        load(16'h1234, 16'h0010, 2'b10); start_op(32'h0001_2340, 0, 16);
        repeat (3) @(negedge clk);
        sw = 16'hAAAA; store_num1 = 1; store_num2 = 1; store_operation = 1;
        @(negedge clk);
        display_32bit_answer = 1; sw = 16'h5555;
        @(negedge clk);
        display_32bit_answer = 0;
        @(negedge clk);
        store_num1 = 0; store_num2 = 0; store_operation = 0;
        // 6 busy cycles consumed above; keep counting from here via a fresh expectation
        sb[0].busy_cycles = 10;
        wait_done("mul_busy");
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) extra++;
            @(negedge clk);
        end
        chk("mul_busy extra_done", extra, 0);
        load(16'h0000, 16'h0000, 2'b10);
        sw = 16'h0000; store_num2 = 1; @(negedge clk); store_num2 = 0;
        sw = 16'h0000; store_operation = 1; @(negedge clk); store_operation = 0;
        @(negedge clk);
        // num_a was overwritten by load above; recapture-free check of op/num_b instead
        load(16'h1234, 16'h0001, 2'b00); start_op(32'h0000_1235, 0, 1); wait_done("post_busy_add");

        // Reset during MUL iteration 5 aborts at once.
        load(16'h1234, 16'h0010, 2'b10);
        display_32bit_answer = 1; @(negedge clk); display_32bit_answer = 0;
        repeat (5) @(negedge clk);
        chk("mid_mul busy", {31'd0, busy}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid answer", answer, 32'd0);
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        load(16'h0002, 16'h0003, 2'b10); start_op(32'h0000_0006, 0, 16); wait_done("mul_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
